// File: rtl/multiple_ls_sequencer.sv
// Thumb LDM/STM/PUSH/POP sequencer: walks the register list lowest-first,
// emits one register/word-address pair per transfer cycle, then one base writeback.
module multiple_ls_sequencer #(
    parameter int ADDR_W = 32,
    parameter int LIST_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        ins_type,
    input  logic [LIST_W-1:0] reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [3:0]        base_reg,
    input  logic              stall,
    output logic              busy,
    output logic              multiple_pulse,
    output logic              multiple_stable,
    output logic [1:0]        multiple_vector,
    output logic              xfer_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        reg_addr,
    output logic [LIST_W-1:0] list_left,
    output logic              wb_en,
    output logic [3:0]        wb_reg,
    output logic [ADDR_W-1:0] wb_data,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [1:0]        type_r;
    logic [LIST_W-1:0] list_r;
    logic [ADDR_W-1:0] addr_r;
    logic [3:0]        base_idx_r;
    logic [ADDR_W-1:0] wb_data_r;
    logic              wb_en_r;
    logic              first_r;

    logic [3:0]        count_s;
    logic              push_s;
    logic [3:0]        base_idx_s;
    logic [ADDR_W-1:0] ofs_s;
    logic [ADDR_W-1:0] start_addr_s;
    logic [ADDR_W-1:0] wb_val_s;
    logic              in_list_s;
    logic              wb_en_val_s;
    logic [LIST_W-1:0] list_clr_s;
    logic              last_s;

    function automatic logic [3:0] popcount(input logic [LIST_W-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < LIST_W; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    // Bit 8 names LR on stores (PUSH) and PC on loads (POP).
    function automatic logic [3:0] lowest_reg(input logic [LIST_W-1:0] v, input logic is_load);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            idx = v[i] ? 4'(i) : idx;
        end
        if (idx == 4'd8) begin
            idx = is_load ? 4'd15 : 4'd14;
        end else begin
            idx = idx;
        end
        return idx;
    endfunction

    // Start-of-operation arithmetic on the incoming request.
    always_comb begin
        count_s      = popcount(reg_list);
        push_s       = (ins_type == 2'b10);
        base_idx_s   = ins_type[1] ? 4'd13 : base_reg;
        ofs_s        = ADDR_W'({count_s, 2'b00});
        start_addr_s = push_s ? (base_addr - ofs_s) : base_addr;
        wb_val_s     = push_s ? (base_addr - ofs_s) : (base_addr + ofs_s);
        if (base_idx_s < 4'd8) begin
            in_list_s = reg_list[base_idx_s[2:0]];
        end else begin
            in_list_s = (base_idx_s == 4'd15) && reg_list[8] && ins_type[0];
        end
        // An LDM that reloads its own base keeps the loaded value.
        wb_en_val_s = !((ins_type == 2'b01) && in_list_s);
        list_clr_s  = list_r & (list_r - LIST_W'(1'b1));
        last_s      = (list_clr_s == {LIST_W{1'b0}});
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = (count_s != 4'd0) ? ST_XFER : ST_WB;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (!stall && last_s) begin
                    state_next_s = ST_WB;
                end else begin
                    state_next_s = ST_XFER;
                end
            end
            ST_WB:   state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Operation context: latched on start, advanced on each unstalled transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            type_r     <= 2'd0;
            list_r     <= {LIST_W{1'b0}};
            addr_r     <= {ADDR_W{1'b0}};
            base_idx_r <= 4'd0;
            wb_data_r  <= {ADDR_W{1'b0}};
            wb_en_r    <= 1'b0;
            first_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        type_r     <= ins_type;
                        list_r     <= reg_list;
                        addr_r     <= start_addr_s;
                        base_idx_r <= base_idx_s;
                        wb_data_r  <= wb_val_s;
                        wb_en_r    <= wb_en_val_s;
                        first_r    <= (count_s != 4'd0);
                    end
                end
                ST_XFER: begin
                    if (!stall) begin
                        list_r  <= list_clr_s;
                        addr_r  <= addr_r + ADDR_W'(3'd4);
                        first_r <= 1'b0;
                    end
                end
                ST_WB:   first_r <= 1'b0;
                default: first_r <= 1'b0;
            endcase
        end
    end

    // Outputs decoded from registered state only, so a stall holds them.
    always_comb begin
        busy            = (state_r != ST_IDLE);
        multiple_vector = type_r;
        list_left       = list_r;
        multiple_pulse  = 1'b0;
        multiple_stable = 1'b0;
        xfer_valid      = 1'b0;
        mem_addr        = {ADDR_W{1'b0}};
        reg_addr        = 4'd0;
        wb_en           = 1'b0;
        wb_reg          = 4'd0;
        wb_data         = {ADDR_W{1'b0}};
        done            = 1'b0;
        case (state_r)
            ST_XFER: begin
                xfer_valid      = 1'b1;
                multiple_stable = 1'b1;
                multiple_pulse  = first_r;
                mem_addr        = addr_r;
                reg_addr        = lowest_reg(list_r, type_r[0]);
            end
            ST_WB: begin
                done    = 1'b1;
                wb_en   = wb_en_r;
                wb_reg  = base_idx_r;
                wb_data = wb_data_r;
            end
            ST_IDLE: done = 1'b0;
            default: done = 1'b0;
        endcase
    end

endmodule
